// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// One outstanding request; responses carry no backpressure.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, one-deep output buffer and imem handshake.
// Define FETCH_STAT_EN to add fetch_count / bubble_count statistics ports.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halted,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_unit_if.master imem,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        consume;
    logic        grant;
    logic        load;
    logic [31:0] redirect_tgt;
    logic        unused_bits;

    assign consume      = valid_q & ~stall & ~halted;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign unused_bits  = ^redirect_pc[1:0];
    assign grant        = imem.imem_req & imem.imem_gnt;
    assign imem.imem_addr = fetch_pc;

    // A redirect in the capture cycle turns the response stale
    assign load = (state == WAIT) & imem.imem_rvalid & ~redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        imem.imem_req = 1'b0;
        unique case (state)
            REQ: begin
                imem.imem_req = ~reset & ~halted & (~valid_q | consume);
                if (grant) begin
                    state_nxt = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    state_nxt = REQ;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem.imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_q     <= RESET_PC;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_tgt;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (grant) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
            end else if (consume) begin
                valid_q <= 1'b0;
            end
            if (load) begin
                instr_q <= imem.imem_rdata;
                pc_q    <= req_pc;
            end
        end
    end

    assign instr_f = valid_q ? instr_q : NOP_INSTR;
    assign pc_f    = pc_q;
    assign pc4_f   = pc_q + 32'd4;

`ifdef FETCH_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (load) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (~valid_q & ~halted) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table plus randomized run
// against a program-order reference model and a latency memory model.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        halted;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
`ifdef FETCH_STAT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    fetch_unit_if imem ();

    fetch_unit #(
        .RESET_PC (RPC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .halted     (halted),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem       (imem),
        .instr_f    (instr_f),
        .pc_f       (pc_f),
        .pc4_f      (pc4_f)
`ifdef FETCH_STAT_EN
        ,
        .fetch_count (fetch_count),
        .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          st;
        bit          ht;
        bit          rd;
        logic [31:0] rpc;
        int          lat;
        bit          req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    vec_t v[$];

    int tests = 0;
    int fails = 0;
    int consumes = 0;
    int lat = 1;

    // reference: exp_pc is the PC of the next instruction in program order
    logic [31:0] exp_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;
    bit          pend;
    bit          pend_stale;
    logic [31:0] pend_addr;
    int          cnt;

    bit          s_reset, s_grant, s_redirect, s_rvalid;
    bit          s_consume, s_invalid, s_halted;
    logic [31:0] s_rpc, s_addr;
    int          s_lat;

    function automatic logic [31:0] ins(logic [31:0] a);
        return a ^ KEY;
    endfunction

    function automatic vec_t row(bit st, bit ht, bit rd, logic [31:0] rpc,
                                 int lt, bit req, logic [31:0] addr,
                                 logic [31:0] instr, logic [31:0] pc);
        vec_t r;
        r.st = st; r.ht = ht; r.rd = rd; r.rpc = rpc; r.lat = lt;
        r.req = req; r.addr = addr; r.instr = instr; r.pc = pc;
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
        end
    endtask

    task automatic model_check();
        bit inv;
        bit exp_req;
        inv = (instr_f === NOP);
        if (!inv) begin
            chk("pc_f", pc_f, exp_pc);
            chk("instr_f", instr_f, ins(exp_pc));
            chk("pc4_f", pc4_f, exp_pc + 32'd4);
        end
        exp_req = !reset && !pend && !halted && (inv || !stall);
        chk("imem_req", {31'd0, imem.imem_req}, {31'd0, exp_req});
        if (exp_req) begin
            chk("imem_addr", imem.imem_addr, inv ? exp_pc : exp_pc + 32'd4);
        end
`ifdef FETCH_STAT_EN
        chk("fetch_count", fetch_count, m_fetch);
        chk("bubble_count", bubble_count, m_bubble);
`endif
        s_reset    = reset;
        s_grant    = imem.imem_req & imem.imem_gnt;
        s_addr     = imem.imem_addr;
        s_redirect = redirect;
        s_rpc      = redirect_pc;
        s_rvalid   = imem.imem_rvalid;
        s_invalid  = inv;
        s_halted   = halted;
        s_consume  = !inv && !stall && !halted;
        s_lat      = lat;
        if (s_consume && !s_reset) consumes++;
    endtask

    task automatic advance();
        if (s_reset) begin
            exp_pc   = RPC;
            m_fetch  = 0;
            m_bubble = 0;
            pend     = 0;
        end else begin
            if (s_invalid && !s_halted) m_bubble = m_bubble + 1;
            if (s_rvalid) begin
                if (!(pend_stale || s_redirect)) m_fetch = m_fetch + 1;
                pend = 0;
            end
            if (s_consume) exp_pc = exp_pc + 32'd4;
            if (s_redirect) begin
                exp_pc = {s_rpc[31:2], 2'b00};
                if (pend) pend_stale = 1;
            end
            if (s_grant) begin
                pend       = 1;
                pend_addr  = s_addr;
                cnt        = s_lat - 1;
                pend_stale = s_redirect;
            end else if (pend && cnt > 0) begin
                cnt--;
            end
        end
        imem.imem_rvalid = pend && (cnt == 0);
        imem.imem_rdata  = imem.imem_rvalid ? ins(pend_addr) : $urandom;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        advance();
    endtask

    initial begin
        int base;
        // c0..c30: throughput, stall, redirect in WAIT, redirect on grant,
        // halted capture, and PC wrap at 2^32
        v.push_back(row(0, 0, 0, 0, 1, 1, 'h100, NOP, 'h100));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h100));
        v.push_back(row(0, 0, 0, 0, 1, 1, 'h104, ins('h100), 'h100));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h100));
        v.push_back(row(1, 0, 0, 0, 1, 0, 0, ins('h104), 'h104));
        v.push_back(row(1, 0, 0, 0, 1, 0, 0, ins('h104), 'h104));
        v.push_back(row(1, 0, 0, 0, 1, 0, 0, ins('h104), 'h104));
        v.push_back(row(0, 0, 0, 0, 3, 1, 'h108, ins('h104), 'h104));
        v.push_back(row(0, 0, 1, 'h203, 1, 0, 0, NOP, 'h104));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h104));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h104));
        v.push_back(row(0, 0, 0, 0, 1, 1, 'h200, NOP, 'h104));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h104));
        v.push_back(row(0, 0, 0, 0, 1, 1, 'h204, ins('h200), 'h200));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h200));
        v.push_back(row(0, 0, 1, 'h400, 2, 1, 'h208, ins('h204), 'h204));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h204));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h204));
        v.push_back(row(0, 0, 0, 0, 1, 1, 'h400, NOP, 'h204));
        v.push_back(row(0, 1, 0, 0, 1, 0, 0, NOP, 'h204));
        v.push_back(row(0, 1, 0, 0, 1, 0, 0, ins('h400), 'h400));
        v.push_back(row(0, 1, 0, 0, 1, 0, 0, ins('h400), 'h400));
        v.push_back(row(0, 0, 0, 0, 1, 1, 'h404, ins('h400), 'h400));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h400));
        v.push_back(row(0, 0, 1, 'hFFFF_FFFF, 1, 1, 'h408, ins('h404), 'h404));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h404));
        v.push_back(row(0, 0, 0, 0, 1, 1, 'hFFFF_FFFC, NOP, 'h404));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'h404));
        v.push_back(row(0, 0, 0, 0, 1, 1, 'h0, ins('hFFFF_FFFC), 'hFFFF_FFFC));
        v.push_back(row(0, 0, 0, 0, 1, 0, 0, NOP, 'hFFFF_FFFC));
        v.push_back(row(0, 0, 0, 0, 1, 1, 'h4, ins('h0), 'h0));

        reset = 1; halted = 0; stall = 0; redirect = 0; redirect_pc = 0;
        imem.imem_gnt = 1; imem.imem_rvalid = 0; imem.imem_rdata = 0;
        exp_pc = RPC; m_fetch = 0; m_bubble = 0;
        pend = 0; pend_stale = 0; pend_addr = 0; cnt = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_instr", instr_f, NOP);
            chk("rst_pc", pc_f, RPC);
            chk("rst_pc4", pc4_f, RPC + 32'd4);
            chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
            model_check();
            @(posedge clk);
            #1;
            advance();
        end
        reset = 0;

        for (int i = 0; i < v.size(); i++) begin
            stall = v[i].st; halted = v[i].ht;
            redirect = v[i].rd; redirect_pc = v[i].rpc;
            lat = v[i].lat; imem.imem_gnt = 1;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'd0, imem.imem_req},
                {31'd0, v[i].req});
            if (v[i].req) chk($sformatf("v%0d_addr", i), imem.imem_addr, v[i].addr);
            chk($sformatf("v%0d_instr", i), instr_f, v[i].instr);
            chk($sformatf("v%0d_pc", i), pc_f, v[i].pc);
            chk($sformatf("v%0d_pc4", i), pc4_f, v[i].pc + 32'd4);
            model_check();
            @(posedge clk);
            #1;
            advance();
        end
`ifdef FETCH_STAT_EN
        chk("dir_fetch_count", fetch_count, 32'd8);
        chk("dir_bubble_count", bubble_count, 32'd17);
`endif

        base = consumes;
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            stall    = ($urandom_range(0, 9) < 3);
            halted   = ($urandom_range(0, 19) == 0);
            redirect = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) begin
                redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            end else begin
                redirect_pc = $urandom_range(0, 65535);
            end
            imem.imem_gnt = ($urandom_range(0, 9) < 7);
            lat = $urandom_range(1, 3);
            step();
        end
        chk("progress", {31'd0, (consumes - base) >= 100}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
